// File: rtl/rr_arb_pkg.sv
// Shared types and the rotating first-set search for the eight-way round-robin arbiter.
package rr_arb_pkg;

  localparam int unsigned N_REQ = 8;
  localparam int unsigned IDX_W = 3;

  typedef enum logic {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_e;

  typedef struct packed {
    logic             found;
    logic [IDX_W-1:0] idx;
  } search_t;

  // Scan upward from ptr, wrapping 7 -> 0; the first set bit wins.
  function automatic search_t rr_search(input logic [N_REQ-1:0] req,
                                        input logic [IDX_W-1:0] ptr);
    search_t          res;
    logic [IDX_W-1:0] cand;
    res.found = 1'b0;
    res.idx   = {IDX_W{1'b0}};
    for (int unsigned k = 0; k < N_REQ; k++) begin
      cand = ptr + IDX_W'(k);
      if (!res.found && req[cand]) begin
        res.found = 1'b1;
        res.idx   = cand;
      end else begin
        res.found = res.found;
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/grant_decoder.sv
// 3-to-8 one-hot decoder with enable; turns the registered owner index into select lines.
module grant_decoder
  import rr_arb_pkg::*;
(
  input  logic [IDX_W-1:0] idx_i,
  input  logic             en_i,
  output logic [N_REQ-1:0] onehot_o
);

  // Decode the owner index; all lines low while no grant is active.
  always_comb begin
    onehot_o = {N_REQ{1'b0}};
    if (en_i) begin
      onehot_o[idx_i] = 1'b1;
    end else begin
      onehot_o = {N_REQ{1'b0}};
    end
  end

endmodule

// File: rtl/rr_grant_arbiter.sv
// Eight-way round-robin arbiter with held grants and a dead cycle between owners.
// Optional forced release after HOLD_MAX cycles when RR_ARB_TIMEOUT_EN is defined.
module rr_grant_arbiter
  import rr_arb_pkg::*;
#(
  parameter int unsigned HOLD_MAX = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [N_REQ-1:0] req_i,
  input  logic             done_i,
  output logic [N_REQ-1:0] gnt_o,
  output logic [IDX_W-1:0] gnt_idx_o,
  output logic             gnt_valid_o,
  output logic             timeout_o
);

  if ((HOLD_MAX < 1) || (HOLD_MAX > 255)) begin : g_hold_max_range
    $error("rr_grant_arbiter: HOLD_MAX must be within 1..255");
  end

  arb_state_e       state_q, state_d;
  logic [IDX_W-1:0] ptr_q, ptr_d;
  logic [IDX_W-1:0] gnt_idx_q, gnt_idx_d;
  logic             gnt_valid_q, gnt_valid_d;
  logic             timeout_q, timeout_d;

  search_t          search_s;
  logic             owner_drop_s;
  logic             limit_s;
  logic             forced_s;
  logic             release_s;

`ifdef RR_ARB_TIMEOUT_EN
  localparam logic [7:0] HOLD_LAST = 8'(HOLD_MAX - 1);
  logic [7:0] hold_cnt_q, hold_cnt_d;
`endif

  // Rotating search and release conditions for the current owner.
  always_comb begin
    search_s     = rr_search(req_i, ptr_q);
    owner_drop_s = ~req_i[gnt_idx_q];
`ifdef RR_ARB_TIMEOUT_EN
    limit_s      = (hold_cnt_q == HOLD_LAST);
`else
    limit_s      = 1'b0;
`endif
    // A limit hit that coincides with a normal release is reported as normal.
    forced_s     = limit_s & ~done_i & ~owner_drop_s;
    release_s    = done_i | owner_drop_s | limit_s;
  end

  // Next-state and next-output logic of the IDLE/GRANT machine.
  always_comb begin
    state_d     = state_q;
    ptr_d       = ptr_q;
    gnt_idx_d   = gnt_idx_q;
    gnt_valid_d = gnt_valid_q;
    timeout_d   = 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
    hold_cnt_d  = hold_cnt_q;
`endif
    case (state_q)
      IDLE: begin
        if (search_s.found) begin
          state_d     = GRANT;
          gnt_idx_d   = search_s.idx;
          gnt_valid_d = 1'b1;
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = 8'd0;
`endif
        end else begin
          gnt_valid_d = 1'b0;
        end
      end
      GRANT: begin
        if (release_s) begin
          state_d     = IDLE;
          gnt_valid_d = 1'b0;
          ptr_d       = gnt_idx_q + IDX_W'(1);
          timeout_d   = forced_s;
        end else begin
`ifdef RR_ARB_TIMEOUT_EN
          hold_cnt_d  = (hold_cnt_q == 8'hFF) ? hold_cnt_q : hold_cnt_q + 8'd1;
`endif
          gnt_valid_d = 1'b1;
        end
      end
      default: begin
        state_d     = IDLE;
        gnt_valid_d = 1'b0;
      end
    endcase
  end

  // State and output registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      ptr_q       <= {IDX_W{1'b0}};
      gnt_idx_q   <= {IDX_W{1'b0}};
      gnt_valid_q <= 1'b0;
      timeout_q   <= 1'b0;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= 8'd0;
`endif
    end else begin
      state_q     <= state_d;
      ptr_q       <= ptr_d;
      gnt_idx_q   <= gnt_idx_d;
      gnt_valid_q <= gnt_valid_d;
      timeout_q   <= timeout_d;
`ifdef RR_ARB_TIMEOUT_EN
      hold_cnt_q  <= hold_cnt_d;
`endif
    end
  end

  grant_decoder u_grant_decoder (
    .idx_i    (gnt_idx_q),
    .en_i     (gnt_valid_q),
    .onehot_o (gnt_o)
  );

  assign gnt_idx_o   = gnt_idx_q;
  assign gnt_valid_o = gnt_valid_q;
  assign timeout_o   = timeout_q;

endmodule

// File: tb/tb_rr_grant_arbiter.sv
// Scoreboard bench for rr_grant_arbiter: a behavioural model queues the expected
// outputs per driven cycle, and they are compared after the following clock edge.
module tb_rr_grant_arbiter;

  localparam int HOLD = 4;

  logic       clk;
  logic       rst_n;
  logic [7:0] req_i;
  logic       done_i;
  logic [7:0] gnt_o;
  logic [2:0] gnt_idx_o;
  logic       gnt_valid_o;
  logic       timeout_o;

  int total = 0;
  int bad   = 0;

  typedef struct packed {
    logic [7:0] gnt;
    logic [2:0] idx;
    logic       v;
    logic       to;
  } exp_t;

  exp_t sb_q[$];

  // model state
  bit m_busy;
  int m_ptr, m_idx, m_cnt;

  rr_grant_arbiter #(.HOLD_MAX(HOLD)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .req_i       (req_i),
    .done_i      (done_i),
    .gnt_o       (gnt_o),
    .gnt_idx_o   (gnt_idx_o),
    .gnt_valid_o (gnt_valid_o),
    .timeout_o   (timeout_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    total++;
    if (obs !== exp_v) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp_v, $time);
    end
  endtask

  // Advance the model by one cycle with the given inputs; return expected outputs.
  task automatic model_step(input logic [7:0] r, input logic d, input logic rn, output exp_t e);
    bit to = 1'b0;
    if (!rn) begin
      m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_cnt = 0;
    end else if (!m_busy) begin
      for (int k = 0; k < 8; k++) begin
        if (!m_busy && r[(m_ptr + k) % 8]) begin
          m_busy = 1'b1;
          m_idx  = (m_ptr + k) % 8;
          m_cnt  = 0;
        end
      end
    end else begin
      bit drop, lim;
      drop = !r[m_idx];
`ifdef RR_ARB_TIMEOUT_EN
      lim = (m_cnt == HOLD - 1);
`else
      lim = 1'b0;
`endif
      if (d || drop || lim) begin
        m_busy = 1'b0;
        m_ptr  = (m_idx + 1) % 8;
        to     = lim && !d && !drop;
      end else if (m_cnt < 255) begin
        m_cnt++;
      end
    end
    e.gnt = m_busy ? (8'd1 << m_idx) : 8'd0;
    e.idx = 3'(m_idx);
    e.v   = m_busy;
    e.to  = to;
  endtask

  // One clock: drive at negedge, queue the expectation, compare after the edge.
  task automatic cyc(input logic [7:0] r, input logic d, input logic rn);
    exp_t e;
    @(negedge clk);
    req_i  = r;
    done_i = d;
    rst_n  = rn;
    model_step(r, d, rn, e);
    sb_q.push_back(e);
    @(posedge clk);
    #1;
    if (sb_q.size() == 0) begin
      chk("sb_underflow", 32'd0, 32'd1);
    end else begin
      e = sb_q.pop_front();
      chk("sb_gnt", 32'(gnt_o), 32'(e.gnt));
      chk("sb_idx", 32'(gnt_idx_o), 32'(e.idx));
      chk("sb_valid", 32'(gnt_valid_o), 32'(e.v));
      chk("sb_timeout", 32'(timeout_o), 32'(e.to));
      chk("onehot", 32'($countones(gnt_o) <= 1), 32'd1);
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int  ngr;
    int  hi;
    bit  prev_v;
    bit  seen_to;
    req_i = 8'h00; done_i = 1'b0; rst_n = 1'b0;
    m_busy = 1'b0; m_ptr = 0; m_idx = 0; m_cnt = 0;

    cyc(8'h00, 1'b0, 1'b0);
    cyc(8'h00, 1'b0, 1'b0);
    chk("reset_gnt", 32'(gnt_o), 32'd0);
    cyc(8'h00, 1'b1, 1'b1);                      // done in IDLE is ignored
    chk("idle_done_valid", 32'(gnt_valid_o), 32'd0);

    // single request, then done; next winner among 0x21 must be 5 (ptr=5)
    cyc(8'h10, 1'b0, 1'b1);
    chk("single_gnt", 32'(gnt_o), 32'h10);
    chk("single_idx", 32'(gnt_idx_o), 32'd4);
    cyc(8'h10, 1'b1, 1'b1);
    chk("single_rel", 32'(gnt_o), 32'd0);
    cyc(8'h21, 1'b0, 1'b1);
    chk("ptr5_idx", 32'(gnt_idx_o), 32'd5);
    cyc(8'h21, 1'b1, 1'b1);
    // wrap priority: ptr=6, req=0x21 -> 0 then 5
    cyc(8'h21, 1'b0, 1'b1);
    chk("wrap_idx0", 32'(gnt_idx_o), 32'd0);
    cyc(8'h21, 1'b1, 1'b1);
    cyc(8'h21, 1'b0, 1'b1);
    chk("wrap_idx5", 32'(gnt_idx_o), 32'd5);
    cyc(8'h00, 1'b1, 1'b1);

    // reset during a live grant to idx 5
    cyc(8'h20, 1'b0, 1'b1);
    chk("pre_rst_idx", 32'(gnt_idx_o), 32'd5);
    cyc(8'h20, 1'b0, 1'b0);
    chk("rst_gnt", 32'(gnt_o), 32'd0);
    chk("rst_idx", 32'(gnt_idx_o), 32'd0);
    chk("rst_valid", 32'(gnt_valid_o), 32'd0);
    chk("rst_timeout", 32'(timeout_o), 32'd0);

    // rotation with req=FF: 0..7,0 with a dead cycle before each grant
    ngr = 0; prev_v = 1'b0;
    for (int c = 0; c < 40 && ngr < 9; c++) begin
      cyc(8'hFF, prev_v, 1'b1);
      if (gnt_valid_o) begin
        chk("rot_idx", 32'(gnt_idx_o), 32'(ngr % 8));
        chk("rot_dead", 32'(prev_v), 32'd0);
        ngr++;
      end
      prev_v = gnt_valid_o;
    end
    chk("rot_count", 32'(ngr), 32'd9);
    cyc(8'h00, 1'b0, 1'b1);

    // implicit release of idx 3, then ptr=4 picks bit 4 from 0x19
    cyc(8'h08, 1'b0, 1'b1);
    chk("impl_idx", 32'(gnt_idx_o), 32'd3);
    cyc(8'h00, 1'b0, 1'b1);
    chk("impl_gnt", 32'(gnt_o), 32'd0);
    chk("impl_to", 32'(timeout_o), 32'd0);
    cyc(8'h19, 1'b0, 1'b1);
    chk("impl_ptr4", 32'(gnt_idx_o), 32'd4);
    cyc(8'h00, 1'b0, 1'b1);

`ifdef RR_ARB_TIMEOUT_EN
    hi = 0; seen_to = 1'b0;
    for (int c = 0; c < 20 && !seen_to; c++) begin
      cyc(8'h02, 1'b0, 1'b1);
      if (timeout_o) begin
        seen_to = 1'b1;
        chk("to_gnt_low", 32'(gnt_o), 32'd0);
      end else if (gnt_valid_o) begin
        hi++;
      end
    end
    chk("to_seen", 32'(seen_to), 32'd1);
    chk("to_hold_cycles", 32'(hi), 32'(HOLD));
    cyc(8'h00, 1'b0, 1'b1);
    chk("to_pulse_end", 32'(timeout_o), 32'd0);
    for (int c = 0; c < HOLD; c++) cyc(8'h02, 1'b0, 1'b1);
    cyc(8'h02, 1'b1, 1'b1);                      // done coincides with limit
    chk("to_done_same", 32'(timeout_o), 32'd0);
    chk("to_done_rel", 32'(gnt_valid_o), 32'd0);
    cyc(8'h00, 1'b0, 1'b1);
`else
    for (int c = 0; c < 3 * HOLD; c++) cyc(8'h02, 1'b0, 1'b1);
    chk("no_to_hold", 32'(gnt_valid_o), 32'd1);
    chk("no_to_pulse", 32'(timeout_o), 32'd0);
    cyc(8'h02, 1'b1, 1'b1);
    cyc(8'h00, 1'b0, 1'b1);
`endif

    // random traffic checked by the scoreboard
    for (int c = 0; c < 300; c++) begin
      cyc(8'($urandom_range(0, 255)) & 8'($urandom_range(0, 255)),
          1'($urandom_range(0, 3) == 0),
          1'($urandom_range(0, 40) != 0));
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
